// File: rtl/bias_stream_sink.sv
// Bias tensor sink: accepts beats over valid/ready into a block-addressed memory and serves registered reads.
// Optional running checksum of the current load is enabled by defining BIAS_SINK_CHECKSUM_EN.
module bias_stream_sink #(
    parameter int BIAS_TENSOR_SIZE_DIM_0 = 32,
    parameter int BIAS_TENSOR_SIZE_DIM_1 = 1,
    parameter int BIAS_PRECISION_0       = 16,
    parameter int BIAS_PARALLELISM_DIM_0 = 1,
    parameter int BIAS_PARALLELISM_DIM_1 = 1,
    parameter int IN_DEPTH               = BIAS_TENSOR_SIZE_DIM_0 / BIAS_PARALLELISM_DIM_0,
    parameter int P                      = BIAS_PARALLELISM_DIM_0 * BIAS_PARALLELISM_DIM_1,
    parameter int AW                     = $clog2(IN_DEPTH) + 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        load_start,
    input  logic [BIAS_PRECISION_0-1:0] data_in [P],
    input  logic                        data_in_valid,
    output logic                        data_in_ready,
    output logic                        loaded,
    input  logic [AW-1:0]               rd_addr,
    input  logic                        rd_en,
    output logic [BIAS_PRECISION_0-1:0] rd_data [P],
    output logic                        rd_valid
`ifdef BIAS_SINK_CHECKSUM_EN
    ,
    output logic [BIAS_PRECISION_0-1:0] checksum
`endif
);

    localparam int W  = BIAS_PRECISION_0;
    localparam int IW = (IN_DEPTH > 1) ? $clog2(IN_DEPTH) : 1;
    localparam logic [AW-1:0] DEPTH_A = AW'(IN_DEPTH);
    localparam logic [IW-1:0] LAST_IDX = IW'(IN_DEPTH - 1);

    // Only one-element-wide tensors along dim 1 are meaningful for this sink.
    generate
        if (BIAS_TENSOR_SIZE_DIM_1 != 1 || BIAS_PARALLELISM_DIM_1 != 1) begin : g_bad_cfg
            $error("bias_stream_sink supports only dim-1 size and parallelism of 1");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state_reg;
    logic [IW-1:0]   cnt_reg;
    logic            ready_reg;
    logic            loaded_reg;
    logic            rd_valid_reg;
    logic [P*W-1:0]  rd_word_reg;
    logic [P*W-1:0]  wr_word;
    logic            beat_accept;
    logic            rd_in_range;

    logic [P*W-1:0]  mem [IN_DEPTH];

    // ready is only ever high in LOAD, so it doubles as the state qualifier.
    assign beat_accept   = data_in_valid && ready_reg;
    assign rd_in_range   = (rd_addr < DEPTH_A);
    assign data_in_ready = ready_reg;
    assign loaded        = loaded_reg;
    assign rd_valid      = rd_valid_reg;

    genvar gi;
    generate
        for (gi = 0; gi < P; gi++) begin : g_lane
            assign wr_word[gi*W +: W] = data_in[gi];
            assign rd_data[gi]        = rd_word_reg[gi*W +: W];
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg  <= IDLE;
            cnt_reg    <= '0;
            ready_reg  <= 1'b0;
            loaded_reg <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (load_start) begin
                        state_reg <= LOAD;
                        cnt_reg   <= '0;
                        ready_reg <= 1'b1;
                    end
                end
                LOAD: begin
                    if (beat_accept) begin
                        if (cnt_reg == LAST_IDX) begin
                            state_reg  <= DONE;
                            cnt_reg    <= '0;
                            ready_reg  <= 1'b0;
                            loaded_reg <= 1'b1;
                        end else begin
                            cnt_reg <= cnt_reg + 1'b1;
                        end
                    end
                end
                DONE: begin
                    if (load_start) begin
                        state_reg  <= LOAD;
                        cnt_reg    <= '0;
                        ready_reg  <= 1'b1;
                        loaded_reg <= 1'b0;
                    end
                end
                default: begin
                    state_reg  <= IDLE;
                    cnt_reg    <= '0;
                    ready_reg  <= 1'b0;
                    loaded_reg <= 1'b0;
                end
            endcase
        end
    end

    // Memory has no reset so it can map onto block RAM; contents survive reset and reload.
    always_ff @(posedge clk) begin
        if (beat_accept) begin
            mem[cnt_reg] <= wr_word;
        end
    end

    // Same-cycle write and read of one address returns the pre-write word.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_word_reg  <= '0;
            rd_valid_reg <= 1'b0;
        end else begin
            rd_valid_reg <= rd_en;
            if (rd_en) begin
                rd_word_reg <= rd_in_range ? mem[rd_addr[IW-1:0]] : '0;
            end
        end
    end

`ifdef BIAS_SINK_CHECKSUM_EN
    logic [W-1:0] checksum_reg;
    logic [W-1:0] checksum_next;

    always_comb begin
        checksum_next = checksum_reg;
        for (int j = 0; j < P; j++) begin
            checksum_next = checksum_next + data_in[j];
        end
    end

    // Cleared only when load_start actually starts a load (it is ignored during LOAD).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            checksum_reg <= '0;
        end else if (load_start && state_reg != LOAD) begin
            checksum_reg <= '0;
        end else if (beat_accept) begin
            checksum_reg <= checksum_next;
        end
    end

    assign checksum = checksum_reg;
`endif

endmodule

// File: tb/tb_bias_stream_sink.sv
// Self-checking bench for bias_stream_sink: table-driven reads, randomized backpressure against a tensor model.
module tb_bias_stream_sink;

    localparam int W     = 16;
    localparam int DEPTH = 32;
    localparam int AW    = 6;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          load_start = 1'b0;
    logic [W-1:0]  data_in [1];
    logic          data_in_valid = 1'b0;
    logic          data_in_ready;
    logic          loaded;
    logic [AW-1:0] rd_addr = '0;
    logic          rd_en = 1'b0;
    logic [W-1:0]  rd_data [1];
    logic          rd_valid;
`ifdef BIAS_SINK_CHECKSUM_EN
    logic [W-1:0]  checksum;
`endif

    bias_stream_sink dut (
        .clk           (clk),
        .rst           (rst),
        .load_start    (load_start),
        .data_in       (data_in),
        .data_in_valid (data_in_valid),
        .data_in_ready (data_in_ready),
        .loaded        (loaded),
        .rd_addr       (rd_addr),
        .rd_en         (rd_en),
        .rd_data       (rd_data),
        .rd_valid      (rd_valid)
`ifdef BIAS_SINK_CHECKSUM_EN
        ,
        .checksum      (checksum)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference: the tensor as it should sit in memory, plus whether a load is in progress.
    logic [W-1:0] model_mem [DEPTH];
    bit           model_loading;
    bit           model_loaded;

    typedef struct {
        logic          en;
        logic [AW-1:0] addr;
        logic [W-1:0]  exp_data;
        logic          exp_valid;
    } rd_vec_t;

    rd_vec_t vecs [8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic start_load();
        load_start = 1'b1;
        step();
        load_start = 1'b0;
        model_loading = 1'b1;
        model_loaded  = 1'b0;
        $display("txn load_start");
        check("ready_after_start", {31'd0, data_in_ready}, 32'd1);
        check("loaded_after_start", {31'd0, loaded}, 32'd0);
    endtask

    // Streams one full tensor of base+k; rnd selects 50% valid plus ignored load_start and an out-of-range read.
    task automatic run_load(input logic [W-1:0] base, input bit rnd);
        int k = 0;
        int c = 0;
        bit v;
        while (k < DEPTH && c < 2000) begin
            v = rnd ? ($urandom_range(0, 1) == 1) : 1'b1;
            data_in[0]    = base + W'(k);
            data_in_valid = v;
            check("ready_in_load", {31'd0, data_in_ready}, {31'd0, model_loading});
            check("loaded_in_load", {31'd0, loaded}, {31'd0, model_loaded});
            if (rnd && c == 5) load_start = 1'b1;
            if (rnd && c == 7) begin
                rd_en   = 1'b1;
                rd_addr = 6'd32;
            end
            step();
            load_start = 1'b0;
            if (v) begin
                model_mem[k] = base + W'(k);
                k++;
            end
            if (rnd && c == 7) begin
                rd_en = 1'b0;
                check("oob_rd_data", {16'd0, rd_data[0]}, 32'd0);
                check("oob_rd_valid", {31'd0, rd_valid}, 32'd1);
            end
            c++;
        end
        if (k < DEPTH) check("load_timeout_beats", k, DEPTH);
        data_in_valid = 1'b0;
        model_loading = 1'b0;
        model_loaded  = 1'b1;
        $display("txn load base=0x%0h beats=%0d cycles=%0d", base, k, c);
        check("loaded_at_end", {31'd0, loaded}, 32'd1);
        check("ready_at_end", {31'd0, data_in_ready}, 32'd0);
        if (!rnd) check("load_cycles", c, DEPTH);
    endtask

    task automatic do_read(input string name, input logic [AW-1:0] addr, input logic [W-1:0] exp);
        rd_en   = 1'b1;
        rd_addr = addr;
        step();
        rd_en = 1'b0;
        $display("txn read addr=%0d data=0x%0h", addr, rd_data[0]);
        check(name, {16'd0, rd_data[0]}, {16'd0, exp});
        check("rd_valid", {31'd0, rd_valid}, 32'd1);
    endtask

    task automatic readback_all();
        for (int a = 0; a < DEPTH; a++) begin
            do_read("readback", AW'(a), model_mem[a]);
        end
    endtask

    initial begin
        data_in[0] = '0;
        model_loading = 1'b0;
        model_loaded  = 1'b0;
        for (int a = 0; a < DEPTH; a++) model_mem[a] = '0;

        // Reset state
        step();
        step();
        check("rst_ready", {31'd0, data_in_ready}, 32'd0);
        check("rst_loaded", {31'd0, loaded}, 32'd0);
        check("rst_rd_valid", {31'd0, rd_valid}, 32'd0);
        check("rst_rd_data", {16'd0, rd_data[0]}, 32'd0);
`ifdef BIAS_SINK_CHECKSUM_EN
        check("rst_checksum", {16'd0, checksum}, 32'd0);
`endif
        rst = 1'b0;
        step();
        data_in_valid = 1'b1;
        data_in[0] = 16'h5555;
        step();
        check("idle_ignores_valid", {31'd0, data_in_ready}, 32'd0);
        data_in_valid = 1'b0;

        // Basic load of 1..32 with valid held high
        start_load();
        run_load(16'h0001, 1'b0);
`ifdef BIAS_SINK_CHECKSUM_EN
        check("checksum_528", {16'd0, checksum}, 32'h0210);
`endif

        // Table-driven reads, including out-of-range addresses and a hold cycle
        vecs[0] = '{1'b1, 6'd0,  model_mem[0],  1'b1};
        vecs[1] = '{1'b1, 6'd31, model_mem[31], 1'b1};
        vecs[2] = '{1'b0, 6'd4,  model_mem[31], 1'b0};
        vecs[3] = '{1'b1, 6'd32, 16'h0000,      1'b1};
        vecs[4] = '{1'b1, 6'd5,  model_mem[5],  1'b1};
        vecs[5] = '{1'b1, 6'd63, 16'h0000,      1'b1};
        vecs[6] = '{1'b0, 6'd7,  16'h0000,      1'b0};
        vecs[7] = '{1'b1, 6'd16, model_mem[16], 1'b1};
        for (int i = 0; i < 8; i++) begin
            rd_en   = vecs[i].en;
            rd_addr = vecs[i].addr;
            step();
            $display("txn vec %0d en=%0b addr=%0d data=0x%0h valid=%0b",
                     i, vecs[i].en, vecs[i].addr, rd_data[0], rd_valid);
            check("vec_rd_data", {16'd0, rd_data[0]}, {16'd0, vecs[i].exp_data});
            check("vec_rd_valid", {31'd0, rd_valid}, {31'd0, vecs[i].exp_valid});
        end
        rd_en = 1'b0;
        readback_all();

        // Backpressure with random valid; ignored load_start and out-of-range read mid-load
        start_load();
        run_load(16'h1000, 1'b1);
        data_in_valid = 1'b1;
        data_in[0] = 16'hDEAD;
        for (int i = 0; i < 4; i++) begin
            step();
            check("no_accept_when_done", {31'd0, data_in_ready}, 32'd0);
        end
        data_in_valid = 1'b0;
        readback_all();

        // Reload
        start_load();
        run_load(16'hA000, 1'b0);
        readback_all();

        // Reset mid-load after 10 beats, with a read in flight
        start_load();
        for (int k = 0; k < 10; k++) begin
            data_in[0] = 16'hB000 + 16'(k);
            data_in_valid = 1'b1;
            rd_en   = (k == 9);
            rd_addr = 6'd3;
            step();
            model_mem[k] = 16'hB000 + 16'(k);
        end
        data_in_valid = 1'b0;
        rd_en = 1'b0;
        check("pre_rst_rd_valid", {31'd0, rd_valid}, 32'd1);
        check("pre_rst_ready", {31'd0, data_in_ready}, 32'd1);
        rst = 1'b1;
        #1;
        $display("txn async reset mid-load");
        check("async_ready", {31'd0, data_in_ready}, 32'd0);
        check("async_loaded", {31'd0, loaded}, 32'd0);
        check("async_rd_valid", {31'd0, rd_valid}, 32'd0);
        check("async_rd_data", {16'd0, rd_data[0]}, 32'd0);
        step();
        rst = 1'b0;
        data_in_valid = 1'b1;
        step();
        check("idle_after_rst", {31'd0, data_in_ready}, 32'd0);
        data_in_valid = 1'b0;
        do_read("stale_partial", 6'd5, model_mem[5]);
        do_read("stale_prev", 6'd20, model_mem[20]);
        start_load();
        run_load(16'hC000, 1'b0);
        do_read("first_beat_addr0", 6'd0, 16'hC000);
        readback_all();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/bias_stream_sink.md
# bias_stream_sink

Receiving end of the parameter-streaming interface: accepts a bias tensor streamed block by block over a valid/ready handshake and stores it in an internal block-addressed memory. Once the full tensor has arrived, the stored blocks are exposed through a registered read port. It sits between a parameter source, or a DMA/host stream, and a compute stage that needs random access to the bias blocks. Reload is on demand.

## Interface
- BIAS_TENSOR_SIZE_DIM_0, default 32: tensor elements along dim 0.
- BIAS_TENSOR_SIZE_DIM_1, default 1: tensor elements along dim 1; the block supports only 1.
- BIAS_PRECISION_0, default 16: element width in bits.
- BIAS_PARALLELISM_DIM_0, default 1: elements per beat along dim 0.
- BIAS_PARALLELISM_DIM_1, default 1: elements per beat along dim 1; the block supports only 1.
- IN_DEPTH, default BIAS_TENSOR_SIZE_DIM_0 / BIAS_PARALLELISM_DIM_0: beats per tensor, and the number of memory entries.
- P, derived as BIAS_PARALLELISM_DIM_0 * BIAS_PARALLELISM_DIM_1: elements per beat.
- AW, derived as $clog2(IN_DEPTH)+1: read address width.

Ports:
- clk  in  1  clock; all state updates on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- load_start  in  1  single-cycle pulse that begins a new tensor load.
- data_in  in  P x BIAS_PRECISION_0  unpacked array of beat elements; element j occupies memory bits [BIAS_PRECISION_0*j +: BIAS_PRECISION_0].
- data_in_valid  in  1  beat available.
- data_in_ready  out  1  sink accepts a beat.
- loaded  out  1  a complete tensor is stored.
- rd_addr  in  AW  block index to read.
- rd_en  in  1  read request.
- rd_data  out  P x BIAS_PRECISION_0  read result, registered.
- rd_valid  out  1  rd_data is valid this cycle.
- checksum  out  BIAS_PRECISION_0  only present when BIAS_SINK_CHECKSUM_EN is defined.

## Operation
- FSM states are IDLE, LOAD and DONE. Reset enters IDLE.
- IDLE:
  - data_in_ready=0 and loaded=0.
  - load_start moves the FSM to LOAD and clears the beat counter.
- LOAD:
  - data_in_ready=1.
  - A beat is accepted when data_in_valid && data_in_ready. It is written to mem[counter], and the counter increments.
  - Accepting the beat at counter==IN_DEPTH-1 resets the counter to 0 and moves the FSM to DONE.
  - load_start while in LOAD is ignored.
- DONE:
  - loaded=1 and data_in_ready=0.
  - load_start returns the FSM to LOAD. loaded drops the next cycle and the counter is 0.
- Read port:
  - Operates in every state.
  - rd_en with rd_addr<IN_DEPTH registers mem[rd_addr] into rd_data.
  - rd_en with rd_addr>=IN_DEPTH registers all-zero data.
  - rd_valid is rd_en delayed by one cycle.
  - When rd_en=0, rd_data holds its previous value.
- Memory contents are not cleared by reset or by load_start. Reads before a completed load return stale or undefined data; software gates reads on loaded.
- A write and a read to the same address in the same cycle return the old data (read-before-write).

## Timing
- Reset values: data_in_ready=0, loaded=0, rd_valid=0, rd_data=0, checksum=0, counter=0, state IDLE.
- load_start asserted in cycle t gives data_in_ready=1 in cycle t+1.
- The last accepted beat in cycle t gives loaded=1 and data_in_ready=0 in cycle t+1.
- Minimum load time is IN_DEPTH cycles after ready rises, with valid held high.
- Read latency is 1 cycle.
- data_in_ready does not depend combinationally on data_in_valid.
- Reset asserted mid-load:
  - Outputs go to their reset values immediately, asynchronously.
  - The partial tensor is abandoned; memory keeps the beats already written.

## Configuration
- BIAS_SINK_CHECKSUM_EN defined:
  - checksum is the modulo-2^BIAS_PRECISION_0 sum of every element accepted in the current load.
  - It clears on load_start and is final when loaded=1.
- Undefined: the checksum port and its logic are absent; all other behaviour is identical.

## Test plan
- Basic load: defaults (IN_DEPTH=32, P=1), pulse load_start, then stream beats 0x0001..0x0020 with valid held high. Required: loaded rises exactly 32 cycles after ready rises; reading addresses 0..31 returns 0x0001..0x0020 one cycle after each rd_en.
- Backpressure gaps: drive valid randomly at 50% with data 0x1000+k. Required: every beat is stored at index k, and no beat is accepted once loaded=1.
- Reload: in DONE, pulse load_start and stream 0xA000+k. Required: loaded=0 the next cycle, and after completion reads return 0xA000+k.
- Reset mid-load: assert rst after beat 10. Required: ready, loaded and rd_valid are 0 asynchronously and the FSM is in IDLE; after a new load_start the first accepted beat writes address 0.
- Out-of-range read: rd_en with rd_addr=32, and load_start pulsed during LOAD. Required: rd_data=0 with rd_valid=1, and the load continues unaffected.
- Checksum (macro defined): load elements 1..32. Required: checksum=528 (0x0210) at loaded=1.
